// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle layout and the reset/NOP bundle values used by the
// decode -> writeback pipeline registers.
package ctrl_pipe_pkg;

  typedef struct packed {
    logic [5:0] rsvd;
    logic       load;
    logic       store;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       wr_en;      // active-low downstream, so it resets high
    logic       rd_en;
    logic       csr_rd_en;
    logic       csr_wr_en;
    logic       mret;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_RST = '{rsvd: '0, load: 1'b0, store: 1'b0, wb_sel: 2'b00,
                                 reg_write: 1'b0, wr_en: 1'b1, rd_en: 1'b0,
                                 csr_rd_en: 1'b0, csr_wr_en: 1'b0, mret: 1'b0};

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline boundary: reset > flush > hold > bubble > load.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH   = CTRL_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             up_stall,
  input  logic [WIDTH-1:0] d_ctrl,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_ctrl,
  output logic             q_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_ctrl  <= RST_VAL;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_ctrl  <= NOP_VAL;
      q_valid <= 1'b0;
    end else if (hold) begin
      q_ctrl  <= q_ctrl;
      q_valid <= q_valid;
    end else if (up_stall) begin
      // upstream is frozen but we are free: emit a bubble
      q_ctrl  <= NOP_VAL;
      q_valid <= 1'b0;
    end else begin
      // invalid input never carries stale control downstream
      q_ctrl  <= d_valid ? d_ctrl : NOP_VAL;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/ctrl_pipe_reg.sv
// Multi-stage control pipeline register with back-propagating stall, per-stage
// flush and a saturating last-stage stall counter.
module ctrl_pipe_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH   = CTRL_W,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] NOP_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          ctrl_in,
  input  logic                      valid_in,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  input  logic                      cnt_clr,
  output logic [WIDTH-1:0]          ctrl_out,
  output logic                      valid_out,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic [STAGES-1:0]         stage_valid,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [STAGES-1:0] es;
  logic [WIDTH-1:0]  sc [STAGES];

  // a stalled stage freezes everything upstream of it
  always_comb begin
    es = '0;
    es[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      es[i] = stall[i] | es[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      ctrl_pipe_stage #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL),
        .NOP_VAL(NOP_VAL)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush[i]),
        .hold    (es[i]),
        .up_stall(1'b0),
        .d_ctrl  (ctrl_in),
        .d_valid (valid_in),
        .q_ctrl  (sc[i]),
        .q_valid (stage_valid[i])
      );
    end else begin : g_next
      ctrl_pipe_stage #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL),
        .NOP_VAL(NOP_VAL)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush[i]),
        .hold    (es[i]),
        .up_stall(es[i-1]),
        .d_ctrl  (sc[i-1]),
        .d_valid (stage_valid[i-1]),
        .q_ctrl  (sc[i]),
        .q_valid (stage_valid[i])
      );
    end
    assign stage_ctrl[i*WIDTH +: WIDTH] = sc[i];
  end

  assign ctrl_out  = sc[STAGES-1];
  assign valid_out = stage_valid[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (es[STAGES-1] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Scoreboard bench for a 3-stage ctrl_pipe_reg with a 4-bit stall counter.
module tb_ctrl_pipe_reg;
  import ctrl_pipe_pkg::*;

  localparam logic [15:0] RSTV = 16'h0010;
  localparam logic [15:0] NOPV = 16'h0000;

  logic        clk;
  logic        rst;
  logic [15:0] ctrl_in;
  logic        valid_in;
  logic [2:0]  stall;
  logic [2:0]  flush;
  logic        cnt_clr;
  logic [15:0] ctrl_out;
  logic        valid_out;
  logic [47:0] stage_ctrl;
  logic [2:0]  stage_valid;
  logic [3:0]  stall_cnt;

  int          n_chk;
  int          n_pass;
  logic [15:0] q[$];
  logic [15:0] last_ctrl;
  logic        last_valid;
  logic [3:0]  exp_cnt;

  ctrl_pipe_reg #(
    .WIDTH  (CTRL_W),
    .STAGES (3),
    .RST_VAL(CTRL_RST),
    .NOP_VAL(CTRL_NOP),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_in    (ctrl_in),
    .valid_in   (valid_in),
    .stall      (stall),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .ctrl_out   (ctrl_out),
    .valid_out  (valid_out),
    .stage_ctrl (stage_ctrl),
    .stage_valid(stage_valid),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sb_drop(input logic [15:0] v);
    int idx;
    idx = -1;
    for (int k = 0; k < q.size(); k++) if (idx < 0 && q[k] == v) idx = k;
    if (idx < 0) chk("sb_drop_missing", 64'(v), 64'hFFFF_FFFF);
    else q.delete(idx);
  endtask

  task automatic monitor(input logic [2:0] s, input logic [2:0] f);
    logic [15:0] e;
    if (f[2]) begin
      chk("flush_out_valid", 64'(valid_out), 64'd0);
      chk("flush_out_ctrl", 64'(ctrl_out), 64'(NOPV));
      last_valid = 1'b0;
    end else if (s[2]) begin
      chk("hold_valid", 64'(valid_out), 64'(last_valid));
      if (last_valid) chk("hold_ctrl", 64'(ctrl_out), 64'(last_ctrl));
      else chk("hold_idle_ctrl", 64'(ctrl_out == NOPV || ctrl_out == RSTV), 64'd1);
    end else if (valid_out) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 64'(ctrl_out), 64'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_ctrl", 64'(ctrl_out), 64'(e));
        last_ctrl  = e;
        last_valid = 1'b1;
      end
    end else begin
      chk("idle_ctrl", 64'(ctrl_out == NOPV || ctrl_out == RSTV), 64'd1);
      last_valid = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic [15:0] c, input logic v,
                      input logic [2:0] s, input logic [2:0] f, input logic clr);
    rst = r; ctrl_in = c; valid_in = v; stall = s; flush = f; cnt_clr = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      last_valid = 1'b0;
    end else if (v && !f[0] && s == 3'b000) begin
      q.push_back(c);
    end
    if (r || clr) exp_cnt = 4'h0;
    else if (s[2] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
    #1;
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    if (!r) monitor(s, f);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; exp_cnt = 4'h0; last_ctrl = NOPV; last_valid = 1'b0;
    rst = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall = '0; flush = '0; cnt_clr = 1'b0;

    // reset with garbage input
    step(1'b1, 16'hFFFF, 1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1, 3'b000, 3'b000, 1'b0);
    chk("rst_ctrl_out", 64'(ctrl_out), 64'h0010);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("rst_stage_ctrl", 64'(stage_ctrl), 64'h0010_0010_0010);

    // streaming, 3-cycle latency
    step(1'b0, 16'h0001, 1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b0, 16'h0002, 1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b0, 16'h0003, 1'b1, 3'b000, 3'b000, 1'b0);
    chk("latency_ctrl", 64'(ctrl_out), 64'h0001);
    chk("latency_valid", 64'(valid_out), 64'd1);
    step(1'b0, 16'h0004, 1'b1, 3'b000, 3'b000, 1'b0);

    // last-stage stall freezes the whole pipe
    step(1'b0, 16'h0005, 1'b1, 3'b100, 3'b000, 1'b0);
    step(1'b0, 16'h0005, 1'b1, 3'b100, 3'b000, 1'b0);
    chk("bp_stage_ctrl", 64'(stage_ctrl), 64'h0002_0003_0004);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);
    step(1'b0, 16'h0005, 1'b1, 3'b000, 3'b000, 1'b0);

    // stage-0 stall inserts a bubble into stage 1
    step(1'b0, 16'h0006, 1'b1, 3'b001, 3'b000, 1'b0);
    chk("bub_stage_valid", 64'(stage_valid), 64'b101);
    chk("bub_stage1_ctrl", 64'(stage_ctrl[31:16]), 64'(NOPV));
    step(1'b0, 16'h0006, 1'b1, 3'b000, 3'b000, 1'b0);
    chk("bub_follow_ctrl", 64'(stage_ctrl[31:16]), 64'h0005);
    step(1'b0, 16'h0007, 1'b1, 3'b000, 3'b000, 1'b0);

    // flush of stage 1 while stages 1 and 2 stall; stage 1 held 0006
    step(1'b0, 16'h0008, 1'b1, 3'b110, 3'b010, 1'b0);
    sb_drop(16'h0006);
    chk("fos_stage_ctrl", 64'(stage_ctrl), 64'h0005_0000_0007);
    chk("fos_stage_valid", 64'(stage_valid), 64'b101);
    step(1'b0, 16'h0008, 1'b1, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("sb_drained", 64'(q.size()), 64'd0);

    // counter: clear, saturate, clear mid-stall, resume
    step(1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b1);
    for (int i = 0; i < 21; i++) step(1'b0, 16'h0000, 1'b0, 3'b100, 3'b000, 1'b0);
    chk("cnt_saturated", 64'(stall_cnt), 64'hF);
    step(1'b0, 16'h0000, 1'b0, 3'b100, 3'b000, 1'b1);
    chk("cnt_clr_wins", 64'(stall_cnt), 64'd0);
    step(1'b0, 16'h0000, 1'b0, 3'b100, 3'b000, 1'b0);
    chk("cnt_resume", 64'(stall_cnt), 64'd1);

    // reset beats stall and flush
    step(1'b0, 16'h00A1, 1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b0, 16'h00A2, 1'b1, 3'b000, 3'b000, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1, 3'b111, 3'b111, 1'b0);
    chk("rst2_stage_ctrl", 64'(stage_ctrl), 64'h0010_0010_0010);
    chk("rst2_stage_valid", 64'(stage_valid), 64'd0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
